// File: rtl/read_arbiter_rr.sv
// Read-channel arbiter: grants one of MASTERS read masters access to a single
// downstream read port (round-robin or fixed priority) and routes the data beats back.
module read_arbiter_rr #(
    parameter int unsigned MASTERS    = 4,
    parameter int unsigned ADDR_WIDTH = 26,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ARB_MODE   = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [MASTERS-1:0]              m_arvalid,
    input  logic [MASTERS*ADDR_WIDTH-1:0]   m_araddr,
    input  logic [MASTERS*4-1:0]            m_arlen,
    output logic [MASTERS-1:0]              m_arready,
    input  logic [MASTERS-1:0]              m_rready,
    output logic [MASTERS-1:0]              m_rvalid,
    output logic [DATA_WIDTH-1:0]           m_rdata,
    output logic                            m_rlast,
    output logic                            ARVALID,
    input  logic                            ARREADY,
    output logic [3:0]                      ARID,
    output logic [3:0]                      ARLEN,
    output logic [ADDR_WIDTH-1:0]           ARADDR,
    input  logic                            RVALID,
    input  logic                            RLAST,
    input  logic [3:0]                      RID,
    input  logic [DATA_WIDTH-1:0]           RDATA,
    output logic                            RREADY,
    output logic                            busy,
    output logic [2:0]                      grant,
    output logic                            id_err,
    output logic                            len_err
);

    localparam int unsigned GW = 3;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                  state_q, state_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic [GW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [3:0]              len_q, len_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    id_err_q, id_err_d;
    logic                    len_err_q, len_err_d;

    logic                    sel_found;
    logic [GW-1:0]           sel_idx;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [3:0]              sel_len;
    logic [MASTERS-1:0]      req_sh;
    logic [MASTERS-1:0]      rready_sh;
    logic                    id_match;

    // Requester search: upward from rr_ptr with wrap (mode 0) or from index 0 (mode 1)
    always_comb begin : arb_select
        int j;
        j         = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        req_sh    = '0;
        for (int k = 0; k < int'(MASTERS); k++) begin
            j      = (ARB_MODE == 0) ? (int'(rr_ptr_q) + k) % int'(MASTERS) : k;
            req_sh = m_arvalid >> j;
            if (!sel_found && req_sh[0]) begin
                sel_found = 1'b1;
                sel_idx   = GW'(j);
            end
        end
        sel_addr = ADDR_WIDTH'(m_araddr >> (int'(sel_idx) * int'(ADDR_WIDTH)));
        sel_len  = 4'(m_arlen >> (int'(sel_idx) * 4));
    end

    // Next-state, beat accounting and per-master routing
    always_comb begin : next_state
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        id_err_d  = id_err_q;
        len_err_d = len_err_q;
        m_arready = '0;
        m_rvalid  = '0;
        RREADY    = 1'b0;
        rready_sh = m_rready >> grant_q;
        id_match  = (RID == {1'b0, grant_q});

        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_d = sel_idx;
                    addr_d  = sel_addr;
                    len_d   = sel_len;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (ARREADY) begin
                    m_arready = MASTERS'(1) << grant_q;
                    cnt_d     = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (RVALID && !id_match) begin
                    // Beats for another ID are drained, never forwarded
                    RREADY   = 1'b1;
                    id_err_d = 1'b1;
                end else begin
                    RREADY   = rready_sh[0];
                    m_rvalid = RVALID ? (MASTERS'(1) << grant_q) : '0;
                    if (RVALID && rready_sh[0]) begin
                        cnt_d = cnt_q + 4'd1;
                        if (RLAST) begin
                            if (cnt_q != len_q) len_err_d = 1'b1;
                            state_d = IDLE;
                            if (ARB_MODE == 0) begin
                                rr_ptr_d = GW'((int'(grant_q) + 1) % int'(MASTERS));
                            end
                        end else if (cnt_q == len_q) begin
                            len_err_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin : regs
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            id_err_q  <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            id_err_q  <= id_err_d;
            len_err_q <= len_err_d;
        end
    end

    assign ARVALID = (state_q == ADDR);
    assign ARID    = {1'b0, grant_q};
    assign ARLEN   = len_q;
    assign ARADDR  = addr_q;
    assign busy    = (state_q != IDLE);
    assign grant   = grant_q;
    assign id_err  = id_err_q;
    assign len_err = len_err_q;
    assign m_rdata = RDATA;
    assign m_rlast = RLAST;

endmodule

// File: tb/tb_read_arbiter_rr.sv
// Bench for read_arbiter_rr: lockstep round-robin and fixed-priority instances,
// table of single-beat grants plus directed multi-cycle sequences.
module tb_read_arbiter_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  m_arvalid = '0;
    logic [103:0] m_araddr = {26'h1C0, 26'h180, 26'h140, 26'h100};
    logic [15:0] m_arlen = '0;
    logic [3:0]  m_rready = 4'b1111;

    logic        arready_a = 0, rvalid_a = 0, rlast_a = 0;
    logic [3:0]  rid_a = '0;
    logic [31:0] rdata_a = '0;
    logic        arready_b = 0, rvalid_b = 0, rlast_b = 0;
    logic [3:0]  rid_b = '0;
    logic [31:0] rdata_b = '0;

    logic [3:0]  m_arready_a, m_rvalid_a, arid_a, arlen_a, m_arready_b, m_rvalid_b, arid_b, arlen_b;
    logic [31:0] m_rdata_a, m_rdata_b;
    logic        m_rlast_a, arvalid_a, rready_a, busy_a, id_err_a, len_err_a;
    logic        m_rlast_b, arvalid_b, rready_b, busy_b, id_err_b, len_err_b;
    logic [25:0] araddr_a, araddr_b;
    logic [2:0]  grant_a, grant_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    read_arbiter_rr #(.MASTERS(4), .ADDR_WIDTH(26), .DATA_WIDTH(32), .ARB_MODE(0)) u_rr (
        .clk(clk), .rst(rst), .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arready(m_arready_a), .m_rready(m_rready), .m_rvalid(m_rvalid_a), .m_rdata(m_rdata_a),
        .m_rlast(m_rlast_a), .ARVALID(arvalid_a), .ARREADY(arready_a), .ARID(arid_a),
        .ARLEN(arlen_a), .ARADDR(araddr_a), .RVALID(rvalid_a), .RLAST(rlast_a), .RID(rid_a),
        .RDATA(rdata_a), .RREADY(rready_a), .busy(busy_a), .grant(grant_a),
        .id_err(id_err_a), .len_err(len_err_a));

    read_arbiter_rr #(.MASTERS(4), .ADDR_WIDTH(26), .DATA_WIDTH(32), .ARB_MODE(1)) u_fp (
        .clk(clk), .rst(rst), .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arready(m_arready_b), .m_rready(m_rready), .m_rvalid(m_rvalid_b), .m_rdata(m_rdata_b),
        .m_rlast(m_rlast_b), .ARVALID(arvalid_b), .ARREADY(arready_b), .ARID(arid_b),
        .ARLEN(arlen_b), .ARADDR(araddr_b), .RVALID(rvalid_b), .RLAST(rlast_b), .RID(rid_b),
        .RDATA(rdata_b), .RREADY(rready_b), .busy(busy_b), .grant(grant_b),
        .id_err(id_err_b), .len_err(len_err_b));

    typedef struct packed {
        logic [3:0] req;
        logic [1:0] g_rr;
        logic [1:0] g_fp;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [25:0] addr_of(input logic [1:0] g);
        return 26'h100 + 26'(g) * 26'h40;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    initial begin
        // req, expected round-robin grant, expected fixed-priority grant
        vecs[0]  = '{4'b1111, 2'd0, 2'd0};
        vecs[1]  = '{4'b1111, 2'd1, 2'd0};
        vecs[2]  = '{4'b1111, 2'd2, 2'd0};
        vecs[3]  = '{4'b1111, 2'd3, 2'd0};
        vecs[4]  = '{4'b1111, 2'd0, 2'd0};
        vecs[5]  = '{4'b1010, 2'd1, 2'd1};
        vecs[6]  = '{4'b1010, 2'd3, 2'd1};
        vecs[7]  = '{4'b1010, 2'd1, 2'd1};
        vecs[8]  = '{4'b0100, 2'd2, 2'd2};
        vecs[9]  = '{4'b1001, 2'd3, 2'd0};
        vecs[10] = '{4'b0001, 2'd0, 2'd0};
        vecs[11] = '{4'b1000, 2'd3, 2'd3};
        vecs[12] = '{4'b0110, 2'd1, 2'd1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_grant", 32'(grant_a), 0);
        chk("rst_arvalid", 32'(arvalid_a), 0);
        chk("rst_errs", 32'({id_err_a, len_err_a}), 0);
        rst = 1'b0;

        // Lockstep 1-beat bursts through both arbiters
        for (int v = 0; v < 13; v++) begin
            m_arvalid = vecs[v].req;
            arready_a = 1'b1;
            arready_b = 1'b1;
            tick();
            chk($sformatf("v%0d_grant_rr", v), 32'(grant_a), 32'(vecs[v].g_rr));
            chk($sformatf("v%0d_grant_fp", v), 32'(grant_b), 32'(vecs[v].g_fp));
            chk($sformatf("v%0d_arid_rr", v), 32'(arid_a), 32'(vecs[v].g_rr));
            chk($sformatf("v%0d_araddr_rr", v), 32'(araddr_a), 32'(addr_of(vecs[v].g_rr)));
            chk($sformatf("v%0d_arready_rr", v), 32'(m_arready_a), 32'(4'b0001 << vecs[v].g_rr));
            m_arvalid = '0;
            tick();
            rvalid_a = 1'b1; rlast_a = 1'b1; rid_a = {2'b00, vecs[v].g_rr};
            rvalid_b = 1'b1; rlast_b = 1'b1; rid_b = {2'b00, vecs[v].g_fp};
            #1;
            chk($sformatf("v%0d_rvalid_rr", v), 32'(m_rvalid_a), 32'(4'b0001 << vecs[v].g_rr));
            chk($sformatf("v%0d_rvalid_fp", v), 32'(m_rvalid_b), 32'(4'b0001 << vecs[v].g_fp));
            tick();
            rvalid_a = 1'b0; rvalid_b = 1'b0;
            chk($sformatf("v%0d_idle_rr", v), 32'(busy_a), 0);
        end
        arready_b = 1'b0;

        // Address held through ARREADY stall, 4-beat burst
        do_reset();
        m_arlen = 16'h0003;
        m_arvalid = 4'b0001;
        arready_a = 1'b0;
        tick();
        chk("stall1_arvalid", 32'(arvalid_a), 1);
        chk("stall1_araddr", 32'(araddr_a), 32'h100);
        chk("stall1_arlen", 32'(arlen_a), 3);
        chk("stall1_arready", 32'(m_arready_a), 0);
        tick();
        chk("stall2_arvalid", 32'(arvalid_a), 1);
        chk("stall2_araddr", 32'(araddr_a), 32'h100);
        chk("stall2_arready", 32'(m_arready_a), 0);
        tick();
        arready_a = 1'b1;
        #1;
        chk("stall3_arvalid", 32'(arvalid_a), 1);
        chk("stall3_arready", 32'(m_arready_a), 4'b0001);
        m_arvalid = '0;
        tick();
        arready_a = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rvalid_a = 1'b1; rid_a = 4'd0; rlast_a = (b == 3); rdata_a = 32'hA000 + 32'(b);
            #1;
            chk($sformatf("beat%0d_rvalid", b), 32'(m_rvalid_a), 4'b0001);
            chk($sformatf("beat%0d_rdata", b), m_rdata_a, 32'hA000 + 32'(b));
            chk($sformatf("beat%0d_rlast", b), 32'(m_rlast_a), 32'(b == 3));
            tick();
        end
        rvalid_a = 1'b0;
        chk("burst4_busy", 32'(busy_a), 0);
        chk("burst4_len_err", 32'(len_err_a), 0);

        // Wrong-ID beat drained and flagged sticky
        do_reset();
        m_arlen = '0;
        m_arvalid = 4'b0100;
        arready_a = 1'b1;
        tick();
        chk("idb_grant", 32'(grant_a), 2);
        m_arvalid = '0;
        tick();
        rvalid_a = 1'b1; rid_a = 4'd1; rlast_a = 1'b1;
        #1;
        chk("idb_rvalid", 32'(m_rvalid_a), 0);
        chk("idb_rready", 32'(rready_a), 1);
        tick();
        chk("idb_id_err", 32'(id_err_a), 1);
        chk("idb_busy", 32'(busy_a), 1);
        rid_a = 4'd2;
        #1;
        chk("idb_good_rvalid", 32'(m_rvalid_a), 4'b0100);
        tick();
        rvalid_a = 1'b0;
        chk("idb_done_busy", 32'(busy_a), 0);
        repeat (3) tick();
        chk("idb_sticky", 32'(id_err_a), 1);
        do_reset();
        #1;
        chk("idb_cleared", 32'(id_err_a), 0);

        // Early RLAST, then reset mid-DATA
        m_arlen = 16'h0003;
        m_arvalid = 4'b0001;
        tick();
        m_arvalid = '0;
        tick();
        for (int b = 0; b < 3; b++) begin
            rvalid_a = 1'b1; rid_a = 4'd0; rlast_a = (b == 2);
            tick();
        end
        rvalid_a = 1'b0;
        chk("early_len_err", 32'(len_err_a), 1);
        chk("early_busy", 32'(busy_a), 0);
        m_arlen = '0;
        m_arvalid = 4'b0010;
        tick();
        chk("rst_mid_grant_pre", 32'(grant_a), 1);
        m_arvalid = '0;
        tick();
        rvalid_a = 1'b1; rid_a = 4'd1; rlast_a = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(busy_a), 0);
        chk("rst_mid_rready", 32'(rready_a), 0);
        chk("rst_mid_rvalid", 32'(m_rvalid_a), 0);
        chk("rst_mid_grant", 32'(grant_a), 0);
        chk("rst_mid_len_err", 32'(len_err_a), 0);
        chk("rst_mid_arvalid", 32'(arvalid_a), 0);
        rst = 1'b0;
        tick();
        chk("stray_rready", 32'(rready_a), 0);
        chk("stray_rvalid", 32'(m_rvalid_a), 0);
        rvalid_a = 1'b0;
        m_arvalid = 4'b1111;
        tick();
        chk("post_rst_grant", 32'(grant_a), 0);
        chk("post_rst_arvalid", 32'(arvalid_a), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/read_arbiter_rr.md
READ_ARBITER_RR -- requirements
Module: read_arbiter_rr

Interface
REQ-001 SHALL provide parameter MASTERS, default 4, number of read masters (legal 1..8).
REQ-002 SHALL provide parameter ADDR_WIDTH, default 26, byte-address width.
REQ-003 SHALL provide parameter DATA_WIDTH, default 32, read data width.
REQ-004 SHALL provide parameter ARB_MODE, default 0, 0 = round-robin, 1 = fixed priority (index 0 highest).
REQ-005 SHALL use one clock; reset is asynchronous and active-high.
REQ-006 SHALL provide clk  input  1  clock, all state on rising edge.
REQ-007 SHALL provide rst  input  1  asynchronous active-high reset.
REQ-008 SHALL provide m_arvalid  input  MASTERS  per-master read request.
REQ-009 SHALL provide m_araddr  input  MASTERS*ADDR_WIDTH  per-master address; master i in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 SHALL provide m_arlen  input  MASTERS*4  per-master burst length minus one.
REQ-011 SHALL provide m_arready  output  MASTERS  per-master request-accepted pulse.
REQ-012 SHALL provide m_rready  input  MASTERS  per-master data-ready.
REQ-013 SHALL provide m_rvalid  output  MASTERS  per-master data-valid.
REQ-014 SHALL provide m_rdata  output  DATA_WIDTH  read data, broadcast to all masters.
REQ-015 SHALL provide m_rlast  output  1  last beat, broadcast.
REQ-016 SHALL provide ARVALID, ARREADY, ARID[3:0], ARLEN[3:0], ARADDR[ADDR_WIDTH-1:0]  out/in/out/out/out  downstream address channel.
REQ-017 SHALL provide RVALID, RLAST, RID[3:0], RDATA[DATA_WIDTH-1:0], RREADY  in/in/in/in/out  downstream data channel.
REQ-018 SHALL provide busy  output  1  state != IDLE; grant  output  3  current grant index.
REQ-019 SHALL provide id_err, len_err  output  1 each  sticky error flags.

Function
REQ-020 SHALL implement FSM states IDLE, ADDR, DATA.
REQ-021 IDLE: if any m_arvalid bit is set, SHALL select one master, latch its index, address and length, and enter ADDR next cycle; otherwise remain in IDLE.
REQ-022 ARB_MODE=0: SHALL select the first requester found searching upward from rr_ptr, wrapping from MASTERS-1 to 0.
REQ-023 ARB_MODE=1: SHALL select the lowest-index requester; rr_ptr unused.
REQ-024 ADDR: SHALL drive ARVALID=1 with ARADDR/ARLEN from latched values and ARID = grant zero-extended, all held stable until ARREADY.
REQ-025 ADDR with ARREADY=1: SHALL pulse m_arready[grant] for exactly that cycle, clear the beat counter, and enter DATA.
REQ-026 m_arvalid changes after latching SHALL be ignored; masters hold requests until m_arready.
REQ-027 DATA: RREADY SHALL equal m_rready[grant] when RID==grant; m_rvalid[grant] SHALL equal RVALID with RID==grant; all other m_rvalid bits SHALL be 0.
REQ-028 DATA beat with RID!=grant: SHALL not forward, SHALL drive RREADY=1 to drain, SHALL set id_err.
REQ-029 Each accepted matching beat (RVALID&&RREADY) SHALL increment the 4-bit beat counter.
REQ-030 Accepted matching beat with RLAST=1: SHALL set len_err if counter != latched ARLEN, SHALL enter IDLE next cycle, and in mode 0 SHALL set rr_ptr = (grant+1) mod MASTERS.
REQ-031 Accepted matching beat with counter==ARLEN but RLAST=0 SHALL set len_err and remain in DATA until RLAST.
REQ-032 IDLE/ADDR: RREADY SHALL be 0; m_rvalid SHALL be all 0.
REQ-033 m_rdata/m_rlast SHALL combinationally follow RDATA/RLAST.
REQ-034 MASTERS=1: grant SHALL always be 0.
REQ-035 Minimum request-to-ARVALID latency SHALL be 1 cycle; back-to-back bursts SHALL incur one IDLE cycle between last beat and the next ARVALID.

Reset
REQ-036 rst asserted SHALL immediately force IDLE, rr_ptr=0, grant=0, counter=0, id_err=0, len_err=0, ARVALID=0, RREADY=0, m_arready=0, m_rvalid=0, busy=0, regardless of state.
REQ-037 Reset during DATA SHALL abandon the burst; subsequent stray RVALID beats SHALL see RREADY=0 until a new grant.

Verification
REQ-038 Mode 0, MASTERS=4, m_arvalid=4'b1111 held, ARREADY=1, 1-beat bursts -> grants 0,1,2,3,0 in order, ARID matches grant.
REQ-039 Mode 1, m_arvalid=4'b1010 held -> grant 1 repeatedly; master 3 never granted while master 1 requests.
REQ-040 m_arlen[0]=3, address 0x100, ARREADY low 2 cycles -> ARVALID held 3 cycles stable, m_arready[0] one pulse, 4 beats forwarded, len_err=0, busy drops after RLAST.
REQ-041 Granted master 2, RID=1 beat injected -> m_rvalid all 0, RREADY=1, id_err=1 sticky until reset.
REQ-042 ARLEN=3 with RLAST on beat 2 -> len_err=1, return to IDLE; rst asserted mid-DATA -> all outputs zero same cycle, next grant starts at master 0.
